hazard_scoreboard: RTL and testbench

Parametrised stall/forward controller for the pipelined MIPS core. It sits beside the D stage and consumes the per-instruction Tuse/Tnew fields produced by the decoders. It keeps a shadow pipeline of pending register writes through the downstream stages and a multi-cycle busy counter for the mult/div unit. From these it drives the D-stage stall and the forward-source selects.

---
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 tb/tb_hazard_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// D-stage stall and forward-select control: a shadow pipeline of pending GPR writes plus an MDU busy counter.
// stall/fwd are combinational from state and D inputs; downstream entries advance every cycle regardless.
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int REGW     = 5,
  parameter int TW       = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int FW       = $clog2(NSTAGE+1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            d_valid,
  input  logic [REGW-1:0] d_rs,
  input  logic [REGW-1:0] d_rt,
  input  logic            d_use_rs,
  input  logic            d_use_rt,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic            d_wr,
  input  logic [REGW-1:0] d_dst,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md_start,
  input  logic            d_md_div,
  input  logic            d_md_use,
  output logic            stall,
  output logic [FW-1:0]   fwd_rs,
  output logic [FW-1:0]   fwd_rt,
  output logic            md_busy
);
  localparam int CW = $clog2(DIV_CYC+1);

  logic [NSTAGE:1]           v_q, v_d;
  logic [NSTAGE:1][REGW-1:0] dst_q, dst_d;
  logic [NSTAGE:1][TW-1:0]   tnew_q, tnew_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [1:0][REGW-1:0] src;
  logic [1:0]           src_use;
  logic [1:0][TW-1:0]   src_tuse;
  logic [1:0]           hit, hazard;
  logic [1:0][TW-1:0]   hit_tnew;
  logic [1:0][FW-1:0]   hit_k, fwd;

  assign src      = {d_rt, d_rs};
  assign src_use  = {d_use_rt, d_use_rs};
  assign src_tuse = {d_tuse_rt, d_tuse_rs};

  // Scan oldest to youngest so the lowest-numbered matching stage wins.
  always_comb begin
    hit      = '0;
    hit_tnew = '0;
    hit_k    = '0;
    hazard   = '0;
    fwd      = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = NSTAGE; k >= 1; k--) begin
        if (src_use[s] && (src[s] != '0) && v_q[k] && (dst_q[k] == src[s])) begin
          hit[s]      = 1'b1;
          hit_tnew[s] = tnew_q[k];
          hit_k[s]    = FW'(k);
        end
      end
      hazard[s] = hit[s] && (hit_tnew[s] > src_tuse[s]);
      fwd[s]    = (hit[s] && (hit_tnew[s] == '0)) ? hit_k[s] : '0;
    end
  end

  assign md_busy = (cnt_q != '0);
  assign stall   = d_valid & ((|hazard) | (d_md_use & md_busy));
  assign fwd_rs  = fwd[0];
  assign fwd_rt  = fwd[1];

  always_comb begin
    v_d    = '0;
    dst_d  = '0;
    tnew_d = '0;
    cnt_d  = cnt_q;
    // A stalled D injects a bubble into E.
    v_d[1]    = ~stall & d_valid & d_wr & (d_dst != '0);
    dst_d[1]  = stall ? '0 : d_dst;
    tnew_d[1] = stall ? '0 : d_tnew;
    for (int k = 2; k <= NSTAGE; k++) begin
      v_d[k]    = v_q[k-1];
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
    if (d_valid && d_md_start && !stall)
      cnt_d = d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      dst_q  <= '0;
      tnew_q <= '0;
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios, then random traffic against an issue-history model.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_use_rs, d_use_rt, d_wr, d_md_start, d_md_div, d_md_use;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NSTAGE(3), .REGW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10), .FW(2)) dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr(d_wr), .d_dst(d_dst),
    .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  typedef struct packed {
    bit       valid;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [1:0] turs, turt;
    bit       wr;
    bit [4:0] dst;
    bit [1:0] tnew;
    bit       mds, mdd, mdu;
  } ins_t;

  typedef struct packed {
    bit       stall;
    bit [1:0] frs, frt;
    bit       busy;
  } exp_t;

  typedef struct packed {
    int       t;
    bit [4:0] dst;
    int       tnew;
  } wr_t;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  wr_t  wq[$];
  exp_t expq[$];
  bit   md_on = 0;
  int   md_t = 0;
  int   md_dur = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic exp_t E(input int s, input int a, input int b, input int m);
    exp_t e;
    e.stall = s[0]; e.frs = a[1:0]; e.frt = b[1:0]; e.busy = m[0];
    return e;
  endfunction

  // dst/rs/rt < 0 means "no write" / "source not read".
  function automatic ins_t mk(input int dst, input int tnew, input int rs, input int turs,
                              input int rt, input int turt);
    ins_t x = '0;
    x.valid = 1'b1;
    x.wr  = (dst >= 0);  x.dst = (dst >= 0) ? 5'(dst) : 5'd0;  x.tnew = 2'(tnew);
    x.urs = (rs >= 0);   x.rs  = (rs >= 0) ? 5'(rs) : 5'd0;    x.turs = 2'(turs);
    x.urt = (rt >= 0);   x.rt  = (rt >= 0) ? 5'(rt) : 5'd0;    x.turt = 2'(turt);
    return x;
  endfunction

  function automatic ins_t mdop(input bit start, input bit div, input int dst);
    ins_t x = mk(dst, 1, -1, 0, -1, 0);
    x.mds = start; x.mdd = div; x.mdu = 1'b1;
    return x;
  endfunction

  // Stage of a recorded write = cycles since it left D; remaining tnew shrinks by one per stage after E.
  function automatic void src_model(input bit u, input bit [4:0] r, input bit [1:0] tu,
                                    output bit hz, output bit [1:0] fw);
    int st;
    int rem;
    bit done;
    hz = 0; fw = 0; done = 0;
    if (u && r != 0) begin
      for (int i = wq.size() - 1; i >= 0; i--) begin
        st = cyc - wq[i].t;
        if (!done && st >= 1 && st <= 3 && wq[i].dst == r) begin
          rem = wq[i].tnew - (st - 1);
          if (rem < 0) rem = 0;
          hz = (rem > int'(tu));
          fw = (rem == 0) ? 2'(st) : 2'd0;
          done = 1;
        end
      end
    end
  endfunction

  function automatic exp_t model(input ins_t x);
    exp_t e;
    bit hr, ht;
    bit [1:0] fr, ft;
    src_model(x.urs, x.rs, x.turs, hr, fr);
    src_model(x.urt, x.rt, x.turt, ht, ft);
    e.busy  = md_on && (cyc - md_t) >= 1 && (cyc - md_t) <= md_dur;
    e.stall = x.valid && (hr || ht || (x.mdu && e.busy));
    e.frs = fr;
    e.frt = ft;
    return e;
  endfunction

  task automatic run_cycle(input ins_t x, input bit rst, input bit hand, input exp_t he,
                           output bit issued);
    exp_t m, e;
    d_valid = x.valid; d_rs = x.rs; d_rt = x.rt; d_use_rs = x.urs; d_use_rt = x.urt;
    d_tuse_rs = x.turs; d_tuse_rt = x.turt; d_wr = x.wr; d_dst = x.dst; d_tnew = x.tnew;
    d_md_start = x.mds; d_md_div = x.mdd; d_md_use = x.mdu;
    reset_n = !rst;
    if (rst) begin
      wq.delete();
      md_on = 0;
    end
    m = model(x);
    expq.push_back(hand ? he : m);
    @(negedge clk);
    e = expq.pop_front();
    check("stall",   int'(stall),   int'(e.stall));
    check("fwd_rs",  int'(fwd_rs),  int'(e.frs));
    check("fwd_rt",  int'(fwd_rt),  int'(e.frt));
    check("md_busy", int'(md_busy), int'(e.busy));
    issued = !rst && x.valid && !m.stall;
    @(posedge clk);
    #1;
    if (issued) begin
      if (x.wr && x.dst != 0) wq.push_back('{t: cyc, dst: x.dst, tnew: int'(x.tnew)});
      if (x.mds) begin
        md_on = 1; md_t = cyc; md_dur = x.mdd ? 10 : 5;
      end
    end
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].t > 3) void'(wq.pop_front());
  endtask

  task automatic h(input ins_t x, input exp_t e);
    bit iss;
    run_cycle(x, 1'b0, 1'b1, e, iss);
  endtask

  task automatic hr(input ins_t x, input exp_t e);
    bit iss;
    run_cycle(x, 1'b1, 1'b1, e, iss);
  endtask

  task automatic nops(input int n, input exp_t e);
    for (int i = 0; i < n; i++) h('0, e);
  endtask

  function automatic ins_t rnd_ins();
    ins_t x = '0;
    x.valid = ($urandom_range(0, 9) < 8);
    x.rs = 5'($urandom_range(0, 3));  x.urs = 1'($urandom_range(0, 1));  x.turs = 2'($urandom_range(0, 3));
    x.rt = 5'($urandom_range(0, 3));  x.urt = 1'($urandom_range(0, 1));  x.turt = 2'($urandom_range(0, 3));
    x.wr = 1'($urandom_range(0, 1));  x.dst = 5'($urandom_range(0, 3)); x.tnew = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 19) == 0) begin
      x.mds = 1'b1; x.mdu = 1'b1; x.mdd = 1'($urandom_range(0, 1));
    end else if ($urandom_range(0, 14) == 0) begin
      x.mdu = 1'b1;
    end
    return x;
  endfunction

  initial begin
    ins_t cur;
    bit   iss, rs_;
    reset_n = 1'b0;
    {d_valid, d_use_rs, d_use_rt, d_wr, d_md_start, d_md_div, d_md_use} = '0;
    {d_rs, d_rt, d_dst, d_tuse_rs, d_tuse_rt, d_tnew} = '0;
    @(posedge clk);
    #1;

    // Outputs held quiet under reset even with a demanding instruction in D.
    hr(mdop(1, 1, 1), E(0, 0, 0, 0));
    hr(mk(-1, 0, 1, 0, 1, 0), E(0, 0, 0, 0));

    // lw $1 (tnew 2) -> addu $2,$1,$3 (tuse 1) -> reader sees lw in stage 3
    h(mk(1, 2, 29, 1, -1, 0), E(0, 0, 0, 0));
    h(mk(2, 1, 1, 1, 3, 1),   E(1, 0, 0, 0));
    h(mk(2, 1, 1, 1, 3, 1),   E(0, 0, 0, 0));
    h(mk(-1, 0, 1, 0, 2, 1),  E(0, 3, 0, 0));
    nops(3, E(0, 0, 0, 0));

    // addu $1 (tnew 1) -> beq $1,$1 (tuse 0)
    h(mk(1, 1, -1, 0, -1, 0), E(0, 0, 0, 0));
    h(mk(-1, 0, 1, 0, 1, 0),  E(1, 0, 0, 0));
    h(mk(-1, 0, 1, 0, 1, 0),  E(0, 2, 2, 0));
    nops(3, E(0, 0, 0, 0));

    // ori $5 (tnew 1) -> sw $5 (tuse_rt 2): no stall, no forward yet
    h(mk(5, 1, -1, 0, -1, 0), E(0, 0, 0, 0));
    h(mk(-1, 0, 29, 1, 5, 2), E(0, 0, 0, 0));
    nops(3, E(0, 0, 0, 0));

    // two writers of $4: youngest (still tnew 1) shadows the forwardable older one
    h(mk(4, 1, -1, 0, -1, 0), E(0, 0, 0, 0));
    h(mk(4, 1, -1, 0, -1, 0), E(0, 0, 0, 0));
    h(mk(-1, 0, 4, 0, -1, 0), E(1, 0, 0, 0));
    h(mk(-1, 0, 4, 0, -1, 0), E(0, 2, 0, 0));
    nops(3, E(0, 0, 0, 0));

    // $0 is never recorded and never matches
    h(mk(0, 3, -1, 0, -1, 0), E(0, 0, 0, 0));
    h(mk(0, 2, 0, 0, 0, 0),   E(0, 0, 0, 0));
    h(mk(-1, 0, 0, 0, 0, 0),  E(0, 0, 0, 0));
    nops(3, E(0, 0, 0, 0));

    // div -> mflo stalls exactly DIV_CYC cycles
    h(mdop(1, 1, -1), E(0, 0, 0, 0));
    for (int i = 0; i < 10; i++) h(mdop(0, 0, 8), E(1, 0, 0, 1));
    h(mdop(0, 0, 8), E(0, 0, 0, 0));
    nops(1, E(0, 0, 0, 0));

    // mult, mult back-to-back: second stalls MULT_CYC cycles
    h(mdop(1, 0, -1), E(0, 0, 0, 0));
    for (int i = 0; i < 5; i++) h(mdop(1, 0, -1), E(1, 0, 0, 1));
    h(mdop(1, 0, -1), E(0, 0, 0, 0));
    nops(5, E(0, 0, 0, 1));
    nops(1, E(0, 0, 0, 0));

    // reset mid-div clears the MDU and pending writes
    h(mdop(1, 1, -1), E(0, 0, 0, 0));
    h(mk(7, 3, -1, 0, -1, 0), E(0, 0, 0, 1));
    h(mdop(0, 0, 9), E(1, 0, 0, 1));
    hr(mdop(0, 0, 9), E(0, 0, 0, 0));
    cur = mk(-1, 0, 7, 0, -1, 0);
    cur.mdu = 1'b1;
    h(cur, E(0, 0, 0, 0));
    nops(3, E(0, 0, 0, 0));

    // random traffic; a stalled instruction is held in D until it issues
    cur = rnd_ins();
    for (int n = 0; n < 600; n++) begin
      rs_ = ($urandom_range(0, 99) == 0);
      run_cycle(cur, rs_, 1'b0, '0, iss);
      if (iss || !cur.valid || rs_) cur = rnd_ins();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
